// File: rtl/loc_to_vector_expander_pkg.sv
// Shared HQC parameter sets, dense-word sizing helpers and the expander FSM encoding.
// Imported by the expander top and its dense store.
package loc_to_vector_expander_pkg;

    typedef struct packed {
        int n;
        int m;
        int weight;
    } hqc_params_t;

    // Vector length, location width and error weight for each security level
    localparam hqc_params_t HQC128 = '{n: 17_669, m: 15, weight: 75};
    localparam hqc_params_t HQC192 = '{n: 35_851, m: 16, weight: 114};
    localparam hqc_params_t HQC256 = '{n: 57_637, m: 16, weight: 149};

    localparam int HQC_E_WIDTH = 32;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    localparam int HQC128_WORDS     = ceil_div(HQC128.n, HQC_E_WIDTH);
    localparam int HQC192_WORDS     = ceil_div(HQC192.n, HQC_E_WIDTH);
    localparam int HQC256_WORDS     = ceil_div(HQC256.n, HQC_E_WIDTH);
    localparam int HQC128_LOG_WORDS = $clog2(HQC128_WORDS);
    localparam int HQC192_LOG_WORDS = $clog2(HQC192_WORDS);
    localparam int HQC256_LOG_WORDS = $clog2(HQC256_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SET,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/loc_to_vector_expander_mem_dual.sv
// Dense word store: one write port, one read port for the internal read-modify-write
// path and one enabled, resettable read port for the external consumer.
module mem_dual
    import loc_to_vector_expander_pkg::*;
#(
    parameter int WIDTH = HQC_E_WIDTH,
    parameter int DEPTH = HQC128_WORDS,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re_a,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic             re_b,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Read-before-write: a same-cycle read of the written word returns the old value
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re_a) begin
            rdata_a <= mem[raddr_a];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_b <= '0;
        end else if (re_b) begin
            rdata_b <= (int'(raddr_b) < DEPTH) ? mem[raddr_b] : '0;
        end
    end

endmodule

// File: rtl/loc_to_vector_expander.sv
// Expands a list of WEIGHT bit locations into a dense N-bit vector held in E_WIDTH-bit words:
// clear the store, then set one bit per location through a two-stage read-modify-write pipe.
module loc_to_vector_expander
    import loc_to_vector_expander_pkg::*;
#(
    parameter int N           = 17_669,
    parameter int M           = 15,
    parameter int WEIGHT      = 75,
    parameter int E_WIDTH     = 32,
    localparam int WORDS      = ceil_div(N, E_WIDTH),
    localparam int LOG_WEIGHT = $clog2(WEIGHT),
    localparam int LOG_WORDS  = $clog2(WORDS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  loc_err,
    output logic                  rd_loc,
    output logic [LOG_WEIGHT-1:0] rd_addr_loc,
    input  logic [M-1:0]          loc,
    input  logic                  rd_e,
    input  logic [LOG_WORDS-1:0]  rd_addr_e,
    output logic [E_WIDTH-1:0]    e
);

    localparam int BIT_W = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;
    localparam int CNT_W = (LOG_WORDS > LOG_WEIGHT) ? LOG_WORDS : LOG_WEIGHT;

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     cnt;
    logic                 accept;
    logic                 clearing;

    logic                 p1_valid;
    logic                 p1_in_range;
    logic                 p1_live;
    logic [LOG_WORDS-1:0] p1_word;
    logic [BIT_W-1:0]     p1_bit;

    logic                 p2_valid;
    logic                 p2_fwd;
    logic [LOG_WORDS-1:0] p2_word;
    logic [BIT_W-1:0]     p2_bit;
    logic [E_WIDTH-1:0]   p2_hold;
    logic [E_WIDTH-1:0]   p2_base;
    logic [E_WIDTH-1:0]   p2_wdata;
    logic [E_WIDTH-1:0]   rmw_rdata;

    logic                 mem_we;
    logic [LOG_WORDS-1:0] mem_waddr;
    logic [E_WIDTH-1:0]   mem_wdata;

    // A start landing on the done cycle is dropped so one request never runs twice
    assign accept = start && (state == ST_IDLE) && !done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        busy        = 1'b0;
        clearing    = 1'b0;
        rd_loc      = 1'b0;
        rd_addr_loc = '0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                busy     = 1'b1;
                clearing = 1'b1;
                if (cnt == CNT_W'(WORDS - 1)) begin
                    state_next = ST_SET;
                end
            end
            ST_SET: begin
                busy        = 1'b1;
                rd_loc      = 1'b1;
                rd_addr_loc = LOG_WEIGHT'(cnt);
                if (cnt == CNT_W'(WEIGHT - 1)) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // One counter serves every phase; it restarts from zero on each state change
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (state_next != state) begin
            cnt <= '0;
        end else if (state != ST_IDLE) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign p1_in_range = 32'(loc) < 32'(N);
    assign p1_live     = p1_valid && p1_in_range;
    assign p1_word     = LOG_WORDS'(32'(loc) / 32'(E_WIDTH));
    assign p1_bit      = BIT_W'(32'(loc) % 32'(E_WIDTH));

    // The store returns pre-write data when P1 reads the word P2 is writing, so P2 reuses its last result
    assign p2_base  = p2_fwd ? p2_hold : rmw_rdata;
    assign p2_wdata = p2_base | (E_WIDTH'(1) << p2_bit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p1_valid <= 1'b0;
            p2_valid <= 1'b0;
            p2_fwd   <= 1'b0;
            p2_word  <= '0;
            p2_bit   <= '0;
            p2_hold  <= '0;
        end else begin
            p1_valid <= rd_loc;
            p2_valid <= p1_live;
            p2_fwd   <= p1_live && p2_valid && (p2_word == p1_word);
            p2_word  <= p1_word;
            p2_bit   <= p1_bit;
            if (p2_valid) begin
                p2_hold <= p2_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done    <= 1'b0;
            loc_err <= 1'b0;
        end else begin
            done <= (state == ST_DRAIN) && (cnt == CNT_W'(1));
            if (accept) begin
                loc_err <= 1'b0;
            end else if (p1_valid && !p1_in_range) begin
                loc_err <= 1'b1;
            end
        end
    end

    assign mem_we    = clearing || p2_valid;
    assign mem_waddr = clearing ? LOG_WORDS'(cnt) : p2_word;
    assign mem_wdata = clearing ? '0 : p2_wdata;

    mem_dual #(
        .WIDTH (E_WIDTH),
        .DEPTH (WORDS)
    ) u_store (
        .clk     (clk),
        .rst     (rst),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .wdata   (mem_wdata),
        .re_a    (p1_live),
        .raddr_a (p1_word),
        .rdata_a (rmw_rdata),
        .re_b    (rd_e && !busy),
        .raddr_b (rd_addr_e),
        .rdata_b (e)
    );

endmodule

// File: tb/tb_loc_to_vector_expander.sv
// Self-checking bench for loc_to_vector_expander: an hqc128 instance driven from a vector table
// plus corner sequences, and an hqc256 instance compared word by word against a reference vector.
module tb_loc_to_vector_expander;

    localparam int N0     = 17_669;
    localparam int W0     = 75;
    localparam int WORDS0 = 553;
    localparam int LAT0   = WORDS0 + W0 + 3;
    localparam int N1     = 57_637;
    localparam int W1     = 149;
    localparam int WORDS1 = 1802;
    localparam int LAT1   = WORDS1 + W1 + 3;

    logic        clk = 1'b0;
    logic        rst;

    logic        start0, busy0, done0, loc_err0, rd_loc0, rd_e0;
    logic [6:0]  rd_addr_loc0;
    logic [14:0] loc0;
    logic [9:0]  rd_addr_e0;
    logic [31:0] e0;

    logic        start1, busy1, done1, loc_err1, rd_loc1, rd_e1;
    logic [7:0]  rd_addr_loc1;
    logic [15:0] loc1;
    logic [10:0] rd_addr_e1;
    logic [31:0] e1;

    int          loc_mem0 [W0];
    int          loc_mem1 [W1];
    logic [31:0] ref1 [WORDS1];

    typedef struct {
        int          sel;
        int          addr;
        logic [31:0] exp;
        string       name;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        string       name;
        int          nloc;
        int          l0, l1, l2, l3;
        int          a0;
        logic [31:0] v0;
        int          a1;
        logic [31:0] v1;
        int          a2;
        logic [31:0] v2;
        logic        err;
    } vec_t;
    vec_t vecs[$];

    int          tests  = 0;
    int          failed = 0;
    int          done_seen;
    int          wait_cycles;
    int unsigned lcg;

    always #5 clk = ~clk;

    loc_to_vector_expander u_dut0 (
        .clk         (clk),
        .rst         (rst),
        .start       (start0),
        .busy        (busy0),
        .done        (done0),
        .loc_err     (loc_err0),
        .rd_loc      (rd_loc0),
        .rd_addr_loc (rd_addr_loc0),
        .loc         (loc0),
        .rd_e        (rd_e0),
        .rd_addr_e   (rd_addr_e0),
        .e           (e0)
    );

    loc_to_vector_expander #(
        .N       (N1),
        .M       (16),
        .WEIGHT  (W1),
        .E_WIDTH (32)
    ) u_dut1 (
        .clk         (clk),
        .rst         (rst),
        .start       (start1),
        .busy        (busy1),
        .done        (done1),
        .loc_err     (loc_err1),
        .rd_loc      (rd_loc1),
        .rd_addr_loc (rd_addr_loc1),
        .loc         (loc1),
        .rd_e        (rd_e1),
        .rd_addr_e   (rd_addr_e1),
        .e           (e1)
    );

    // Location memories answer one cycle after each read request
    always_ff @(posedge clk) begin
        if (rd_loc0) loc0 <= 15'(loc_mem0[rd_addr_loc0]);
        if (rd_loc1) loc1 <= 16'(loc_mem1[rd_addr_loc1]);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic getBusy(input int sel);
        return (sel == 0) ? busy0 : busy1;
    endfunction

    function automatic logic getDone(input int sel);
        return (sel == 0) ? done0 : done1;
    endfunction

    function automatic logic getErr(input int sel);
        return (sel == 0) ? loc_err0 : loc_err1;
    endfunction

    function automatic logic [31:0] getE(input int sel);
        return (sel == 0) ? e0 : e1;
    endfunction

    task automatic setStart(input int sel, input logic v);
        if (sel == 0) start0 = v;
        else          start1 = v;
    endtask

    task automatic setRdE(input int sel, input logic en, input int addr);
        if (sel == 0) begin
            rd_e0      = en;
            rd_addr_e0 = 10'(addr);
        end else begin
            rd_e1      = en;
            rd_addr_e1 = 11'(addr);
        end
    endtask

    task automatic readWord(input int sel, input int addr, input logic [31:0] exp, input string name);
        sb_t item;
        @(negedge clk);
        setRdE(sel, 1'b1, addr);
        item.sel  = sel;
        item.addr = addr;
        item.exp  = exp;
        item.name = $sformatf("%s_w%0d", name, addr);
        sb_q.push_back(item);
        @(negedge clk);
        setRdE(sel, 1'b0, 0);
        item = sb_q.pop_front();
        checkOutput(item.name, getE(item.sel), item.exp);
    endtask

    // Runs one expansion; also pokes start while busy and again on the done cycle, both to be ignored
    task automatic runExpansion(input int sel, input int exp_lat, input bit probe, input logic [31:0] hold_val);
        int cycles;
        @(negedge clk);
        setStart(sel, 1'b1);
        @(negedge clk);
        setStart(sel, 1'b0);
        cycles = 1;
        checkOutput("busy_after_start", 32'(getBusy(sel)), 32'd1);
        checkOutput("loc_err_cleared_on_start", 32'(getErr(sel)), 32'd0);
        while (!getDone(sel) && cycles < 4000) begin
            if (cycles == 4) setStart(sel, 1'b1);
            if (cycles == 5) setStart(sel, 1'b0);
            if (probe && cycles == 6) setRdE(sel, 1'b1, 1);
            if (probe && cycles == 7) begin
                setRdE(sel, 1'b0, 0);
                checkOutput("e_hold_while_busy", getE(sel), hold_val);
            end
            @(negedge clk);
            cycles++;
        end
        checkOutput("start_to_done_latency", 32'(cycles), 32'(exp_lat));
        checkOutput("busy_low_with_done", 32'(getBusy(sel)), 32'd0);
        setStart(sel, 1'b1);
        @(negedge clk);
        setStart(sel, 1'b0);
        checkOutput("start_with_done_ignored", 32'(getBusy(sel)), 32'd0);
        checkOutput("done_single_pulse", 32'(getDone(sel)), 32'd0);
    endtask

    task automatic applyStimulus(input vec_t v);
        int ls [4];
        ls = '{v.l0, v.l1, v.l2, v.l3};
        for (int i = 0; i < W0; i++) begin
            loc_mem0[i] = (i < v.nloc) ? ls[i] : ls[v.nloc - 1];
        end
        runExpansion(0, LAT0, 1'b0, 32'd0);
        checkOutput({v.name, "_loc_err"}, 32'(loc_err0), 32'(v.err));
        readWord(0, v.a0, v.v0, v.name);
        readWord(0, v.a1, v.v1, v.name);
        readWord(0, v.a2, v.v2, v.name);
    endtask

    function automatic vec_t mkVec(input string name, input int nloc,
                                   input int l0, input int l1, input int l2, input int l3,
                                   input int a0, input logic [31:0] v0,
                                   input int a1, input logic [31:0] v1,
                                   input int a2, input logic [31:0] v2,
                                   input logic err);
        vec_t v;
        v.name = name; v.nloc = nloc;
        v.l0 = l0; v.l1 = l1; v.l2 = l2; v.l3 = l3;
        v.a0 = a0; v.v0 = v0; v.a1 = a1; v.v1 = v1; v.a2 = a2; v.v2 = v2;
        v.err = err;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst    = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        setRdE(0, 1'b0, 0);
        setRdE(1, 1'b0, 0);

        vecs.push_back(mkVec("basic",     4, 0, 31, 32, 17_668,   0, 32'h8000_0001,   1, 32'h0000_0001, 552, 32'h0000_0010, 1'b0));
        vecs.push_back(mkVec("fwd_567",   3, 5, 6, 7, 0,          0, 32'h0000_00E0,   1, 32'h0000_0000, 552, 32'h0000_0000, 1'b0));
        vecs.push_back(mkVec("dup_100",   2, 100, 100, 0, 0,      3, 32'h0000_0010,   2, 32'h0000_0000,   4, 32'h0000_0000, 1'b0));
        vecs.push_back(mkVec("loc_eq_n",  1, 17_669, 0, 0, 0,   552, 32'h0000_0000,   0, 32'h0000_0000,   3, 32'h0000_0000, 1'b1));
        vecs.push_back(mkVec("mixed_err", 3, 1, 32_767, 2, 0,     0, 32'h0000_0006, 552, 32'h0000_0000,   1, 32'h0000_0000, 1'b1));
        vecs.push_back(mkVec("alt_words", 4, 0, 32, 1, 33,        0, 32'h0000_0003,   1, 32'h0000_0003,   2, 32'h0000_0000, 1'b0));
        vecs.push_back(mkVec("edges",     3, 17_664, 17_663, 63, 0, 552, 32'h0000_0001, 551, 32'h8000_0000, 1, 32'h8000_0000, 1'b0));

        repeat (3) @(negedge clk);
        checkOutput("reset_busy",        32'(busy0),        32'd0);
        checkOutput("reset_done",        32'(done0),        32'd0);
        checkOutput("reset_loc_err",     32'(loc_err0),     32'd0);
        checkOutput("reset_rd_loc",      32'(rd_loc0),      32'd0);
        checkOutput("reset_rd_addr_loc", 32'(rd_addr_loc0), 32'd0);
        checkOutput("reset_e",           e0,                32'd0);
        checkOutput("reset_busy_h256",   32'(busy1),        32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
        end

        // e must keep showing the last read word while an expansion runs
        readWord(0, 1, 32'h8000_0000, "pre_hold");
        for (int i = 0; i < W0; i++) loc_mem0[i] = 0;
        runExpansion(0, LAT0, 1'b1, 32'h8000_0000);
        readWord(0, 0, 32'h0000_0001, "after_hold");
        readWord(0, 1, 32'h0000_0000, "after_hold");

        // Abort in the middle of SET, then a clean rerun
        for (int i = 0; i < W0; i++) loc_mem0[i] = 200;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_cycles = 0;
        while (!(rd_loc0 && rd_addr_loc0 == 7'd10) && wait_cycles < 2000) begin
            @(negedge clk);
            wait_cycles++;
        end
        checkOutput("reached_set_cycle_10", 32'(rd_loc0 && rd_addr_loc0 == 7'd10), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("abort_busy",        32'(busy0),        32'd0);
        checkOutput("abort_done",        32'(done0),        32'd0);
        checkOutput("abort_rd_loc",      32'(rd_loc0),      32'd0);
        checkOutput("abort_rd_addr_loc", 32'(rd_addr_loc0), 32'd0);
        checkOutput("abort_loc_err",     32'(loc_err0),     32'd0);
        checkOutput("abort_e",           e0,                32'd0);
        @(negedge clk);
        rst = 1'b1;
        done_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done0) done_seen++;
        end
        checkOutput("no_done_after_abort", 32'(done_seen), 32'd0);
        runExpansion(0, LAT0, 1'b0, 32'd0);
        readWord(0, 6, 32'h0000_0100, "rerun");
        readWord(0, 0, 32'h0000_0000, "rerun");

        // hqc256 list against a dense reference vector
        lcg = 32'h2545_F491;
        for (int i = 0; i < W1; i++) begin
            lcg = lcg * 32'd1_664_525 + 32'd1_013_904_223;
            loc_mem1[i] = int'((lcg >> 8) % 32'(N1));
        end
        loc_mem1[0]      = 0;
        loc_mem1[10]     = 64;
        loc_mem1[11]     = 65;
        loc_mem1[12]     = 65;
        loc_mem1[W1 - 1] = N1 - 1;
        for (int w = 0; w < WORDS1; w++) ref1[w] = 32'd0;
        for (int i = 0; i < W1; i++) ref1[loc_mem1[i] / 32][loc_mem1[i] % 32] = 1'b1;
        runExpansion(1, LAT1, 1'b0, 32'd0);
        checkOutput("h256_loc_err", 32'(loc_err1), 32'd0);
        for (int w = 0; w < WORDS1; w++) begin
            readWord(1, w, ref1[w], "h256");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/loc_to_vector_expander.md
LOC_TO_VECTOR_EXPANDER -- requirements
Module: loc_to_vector_expander

Interface
REQ-001 SHALL have parameter N, default 17_669, meaning the vector length in bits.
REQ-002 SHALL have parameter M, default 15, meaning the location width in bits.
REQ-003 SHALL have parameter WEIGHT, default 75, meaning the number of locations per vector.
REQ-004 SHALL have parameter E_WIDTH, default 32, meaning the dense word width; WORDS = ceil(N/E_WIDTH); LOG_WEIGHT = CLOG2(WEIGHT); LOG_WORDS = CLOG2(WORDS).
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port start, input, 1 bit: single-cycle request to expand one location list.
REQ-008 SHALL have port busy, output, 1 bit: high while an expansion is in progress.
REQ-009 SHALL have port done, output, 1 bit: single-cycle pulse when the expansion completes.
REQ-010 SHALL have port loc_err, output, 1 bit: sticky flag set when a location is at or above N; cleared on start.
REQ-011 SHALL have port rd_loc, output, 1 bit: location memory read enable.
REQ-012 SHALL have port rd_addr_loc, output, LOG_WEIGHT bits: location memory read address.
REQ-013 SHALL have port loc, input, M bits: location data, valid 1 cycle after rd_loc.
REQ-014 SHALL have port rd_e, input, 1 bit: dense vector read enable.
REQ-015 SHALL have port rd_addr_e, input, LOG_WORDS bits: dense vector word address.
REQ-016 SHALL have port e, output, E_WIDTH bits: dense word, valid 1 cycle after rd_e.

Function
REQ-017 SHALL implement the FSM IDLE -> CLEAR -> SET -> DRAIN -> IDLE; start is accepted only in IDLE and ignored otherwise.
REQ-018 In CLEAR, SHALL write zero to words 0..WORDS-1, one word per cycle (WORDS cycles).
REQ-019 In SET, SHALL issue rd_loc with addresses 0..WEIGHT-1, one per cycle.
REQ-020 SHALL pipeline each location as: P1 loc returned, word index = loc / E_WIDTH, bit = loc % E_WIDTH, internal RAM read issued; P2 word returned, OR one-hot(bit), write back.
REQ-021 SHALL forward the P2 write data into P2 when consecutive locations hit the same word, so that no set bit is lost.
REQ-022 SHALL treat duplicate locations as idempotent.
REQ-023 SHALL not write a location at or above N, and SHALL set loc_err for it.
REQ-024 DRAIN SHALL last 2 cycles; done SHALL pulse on the cycle busy falls.
REQ-025 Latency from the start cycle to done SHALL be exactly WORDS + WEIGHT + 3 cycles.
REQ-026 SHALL service rd_e only when busy is low; while busy, e SHALL hold its last value.
REQ-027 Bits at or above N in the last word SHALL read 0.
REQ-028 start coincident with done SHALL be ignored.

Reset
REQ-029 On rst low, the FSM SHALL go to IDLE, and busy, done, loc_err, rd_loc, rd_addr_loc and e SHALL all be 0.
REQ-030 Reset mid-operation SHALL abort without a done pulse; the RAM contents are then undefined until the next completed expansion.

Structure
REQ-031 Parameter-set tables (N, M, WEIGHT per hqc128/192/256), WORDS, LOG_WORDS and the FSM state encoding SHALL live in the shared hqc package.
REQ-032 The dense store SHALL be one sub-module, mem_dual (1 write port, 2 read ports: internal RMW and external), WIDTH = E_WIDTH, DEPTH = WORDS.

Verification
REQ-033 hqc128 with locations {0, 31, 32, 17_668, ...}: words 0 and 1 read 0x80000001 and 0x00000001; word 552 bit 4 is set; done arrives 553 + 75 + 3 = 631 cycles after start.
REQ-034 Back-to-back locations 5, 6, 7 (same word): word 0 = 0x000000E0 (forwarding check).
REQ-035 Duplicates 100, 100: only word 3 bit 4 is set; loc_err = 0.
REQ-036 Location 17_669 injected: loc_err = 1 and no bit is written; the next start clears loc_err.
REQ-037 rst low at SET cycle 10: busy = 0 and no done pulse; a new start completes with the full latency.
REQ-038 hqc256 against a fixed_weight_cww_opt output list: the dense words match the software reference.
